// File: rtl/i2s_frame_scheduler.sv
// ---------------------------------------------------------------------------
// i2s_frame_scheduler
//
// Per-frame channel scheduler ahead of the AXIS-to-I2S datapath. Once per
// audio frame it collects one 32-bit sample from every enabled channel
// source, in ascending channel order, and forwards them on one AXI-Stream
// with the channel index on tid. Channels still missing when the next frame
// tick arrives are replaced by zero samples so slot alignment is preserved.
//
// Ports:
//   aud_mclk, aud_mrst        clock, asynchronous active-high reset
//   enable                    scheduler enable
//   ch_mask[NUM_CH]           channel enable mask, latched at frame start
//   frame_tick                one-cycle frame-start strobe
//   s_ch_tvalid/tdata/tready  per-channel sources (channel i at [32i+:32])
//   m_axis_aud_*              scheduled output stream (single register stage)
//   underrun_pulse            one-cycle strobe per underrun
//   underrun_cnt[CNT_W]       saturating underrun count
//   busy                      frame in progress or output pending
// ---------------------------------------------------------------------------
module i2s_frame_scheduler #(
   parameter int unsigned NUM_CH = 8,
   parameter int unsigned CH_W   = 3,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                  aud_mclk,
   input  logic                  aud_mrst,
   input  logic                  enable,
   input  logic [NUM_CH-1:0]     ch_mask,
   input  logic                  frame_tick,
   input  logic [NUM_CH-1:0]     s_ch_tvalid,
   input  logic [NUM_CH*32-1:0]  s_ch_tdata,
   output logic [NUM_CH-1:0]     s_ch_tready,
   output logic [31:0]           m_axis_aud_tdata,
   output logic [CH_W-1:0]       m_axis_aud_tid,
   output logic                  m_axis_aud_tvalid,
   input  logic                  m_axis_aud_tready,
   output logic                  m_axis_aud_tlast,
   output logic                  underrun_pulse,
   output logic [CNT_W-1:0]      underrun_cnt,
   output logic                  busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_WAIT = 2'd2,
      S_FILL = 2'd3
   } state_t;

   state_t              r_state;
   logic [NUM_CH-1:0]   r_mask;
   logic [CH_W-1:0]     r_cur;
   logic                r_pend;
   logic [31:0]         r_tdata;
   logic [CH_W-1:0]     r_tid;
   logic                r_tvalid;
   logic                r_tlast;
   logic                r_pulse;
   logic [CNT_W-1:0]    r_cnt;

   logic                w_slot_free;
   logic                w_cur_valid;
   logic [31:0]         w_cur_data;
   logic                w_cur_last;
   logic [CH_W-1:0]     w_next;
   logic                w_acc;
   logic                w_fill_emit;
   logic                w_load;
   logic [CH_W-1:0]     w_new_first;

   // lowest set bit of m (0 when m is empty; callers check |m separately)
   function automatic logic [CH_W-1:0] f_lowest(input logic [NUM_CH-1:0] m);
      f_lowest = '0;
      for (int unsigned i = NUM_CH; i > 0; i--)
         if (m[i-1]) f_lowest = CH_W'(i-1);
   endfunction

   // lowest set bit strictly above c (returns c if none)
   function automatic logic [CH_W-1:0] f_next(input logic [NUM_CH-1:0] m,
                                              input logic [CH_W-1:0]   c);
      f_next = c;
      for (int unsigned i = NUM_CH; i > 0; i--)
         if (m[i-1] && ((i-1) > 32'(c))) f_next = CH_W'(i-1);
   endfunction

   function automatic logic f_has_above(input logic [NUM_CH-1:0] m,
                                        input logic [CH_W-1:0]   c);
      f_has_above = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++)
         if (m[i] && (i > 32'(c))) f_has_above = 1'b1;
   endfunction

   assign w_slot_free = !r_tvalid || m_axis_aud_tready;
   assign w_cur_last  = !f_has_above(r_mask, r_cur);
   assign w_next      = f_next(r_mask, r_cur);
   assign w_new_first = f_lowest(ch_mask);

   always_comb begin
      w_cur_valid = 1'b0;
      w_cur_data  = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (CH_W'(i) == r_cur) begin
            w_cur_valid = s_ch_tvalid[i];
            w_cur_data  = s_ch_tdata[32*i +: 32];
         end
      end
   end

   // Ready follows the output slot combinationally and drops with enable.
   always_comb begin
      s_ch_tready = '0;
      if (r_state == S_WAIT && enable && w_slot_free) begin
         for (int unsigned i = 0; i < NUM_CH; i++)
            if (CH_W'(i) == r_cur) s_ch_tready[i] = 1'b1;
      end
   end

   assign w_acc       = (r_state == S_WAIT) && enable && w_slot_free && w_cur_valid;
   assign w_fill_emit = (r_state == S_FILL) && enable && w_slot_free;
   assign w_load      = w_acc || w_fill_emit;

   always_ff @(posedge aud_mclk or posedge aud_mrst) begin
      if (aud_mrst) begin
         r_state  <= S_IDLE;
         r_mask   <= '0;
         r_cur    <= '0;
         r_pend   <= 1'b0;
         r_tdata  <= '0;
         r_tid    <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_pulse  <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_pulse <= 1'b0;

         // output register: drop when consumed, reload on accept or fill
         if (w_slot_free) r_tvalid <= 1'b0;
         if (w_load) begin
            r_tvalid <= 1'b1;
            r_tdata  <= (r_state == S_WAIT) ? w_cur_data : '0;
            r_tid    <= r_cur;
            r_tlast  <= w_cur_last;
         end

         if (!enable && r_state != S_IDLE) begin
            // abandon the frame; leave only once the held output is taken
            r_pend <= 1'b0;
            if (w_slot_free) r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (enable) r_state <= S_ARM;
               end
               S_ARM: begin
                  if (frame_tick) begin
                     r_mask <= ch_mask;
                     if (|ch_mask) begin
                        r_cur   <= w_new_first;
                        r_state <= S_WAIT;
                     end
                  end
               end
               S_WAIT: begin
                  if (frame_tick && !(w_acc && w_cur_last)) begin
                     // underrun; a same-cycle accept moves fill past it
                     r_pulse <= 1'b1;
                     if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                     r_pend  <= 1'b1;
                     r_state <= S_FILL;
                     if (w_acc) r_cur <= w_next;
                  end else if (w_acc) begin
                     if (w_cur_last) begin
                        // a tick coinciding with the last accept opens a new frame
                        if (frame_tick) begin
                           r_mask <= ch_mask;
                           if (|ch_mask) r_cur <= w_new_first;
                           else          r_state <= S_ARM;
                        end else begin
                           r_state <= S_ARM;
                        end
                     end else begin
                        r_cur <= w_next;
                     end
                  end
               end
               S_FILL: begin
                  if (w_fill_emit) begin
                     if (w_cur_last) begin
                        if (r_pend) begin
                           r_pend <= 1'b0;
                           r_mask <= ch_mask;
                           if (|ch_mask) begin
                              r_cur   <= w_new_first;
                              r_state <= S_WAIT;
                           end else begin
                              r_state <= S_ARM;
                           end
                        end else begin
                           r_state <= S_ARM;
                        end
                     end else begin
                        r_cur <= w_next;
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign m_axis_aud_tdata  = r_tdata;
   assign m_axis_aud_tid    = r_tid;
   assign m_axis_aud_tvalid = r_tvalid;
   assign m_axis_aud_tlast  = r_tlast;
   assign underrun_pulse    = r_pulse;
   assign underrun_cnt      = r_cnt;
   assign busy              = (r_state == S_WAIT) || (r_state == S_FILL) || r_tvalid;

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_i2s_frame_scheduler
//
// Scoreboard bench: expected (tid, data, last) entries are queued when the
// stimulus is driven and popped when an output handshake completes.
// ---------------------------------------------------------------------------
module tb_i2s_frame_scheduler;

   localparam int unsigned NUM_CH = 8;
   localparam int unsigned CH_W   = 3;
   localparam int unsigned CNT_W  = 8;

   logic                  clk;
   logic                  rst;
   logic                  enable;
   logic [NUM_CH-1:0]     ch_mask;
   logic                  frame_tick;
   logic [NUM_CH-1:0]     s_tvalid;
   logic [NUM_CH*32-1:0]  s_tdata;
   logic [NUM_CH-1:0]     s_tready;
   logic [31:0]           m_tdata;
   logic [CH_W-1:0]       m_tid;
   logic                  m_tvalid;
   logic                  m_tready;
   logic                  m_tlast;
   logic                  u_pulse;
   logic [CNT_W-1:0]      u_cnt;
   logic                  busy;

   i2s_frame_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
      .aud_mclk          (clk),
      .aud_mrst          (rst),
      .enable            (enable),
      .ch_mask           (ch_mask),
      .frame_tick        (frame_tick),
      .s_ch_tvalid       (s_tvalid),
      .s_ch_tdata        (s_tdata),
      .s_ch_tready       (s_tready),
      .m_axis_aud_tdata  (m_tdata),
      .m_axis_aud_tid    (m_tid),
      .m_axis_aud_tvalid (m_tvalid),
      .m_axis_aud_tready (m_tready),
      .m_axis_aud_tlast  (m_tlast),
      .underrun_pulse    (u_pulse),
      .underrun_cnt      (u_cnt),
      .busy              (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [CH_W-1:0] tid;
      logic [31:0]     data;
      logic            last;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_bad = 0;
   int   n_pulse = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int ch, input bit zero, input bit last);
      exp_t e;
      e.tid  = CH_W'(ch);
      e.data = zero ? 32'h0 : (32'h1111_0000 + 32'(ch));
      e.last = last;
      sb.push_back(e);
   endtask

   task automatic pulse_tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   // output monitor: scoreboard pop plus hold-stability under backpressure
   logic            prev_hold = 1'b0;
   logic [31:0]     hold_data;
   logic [CH_W-1:0] hold_tid;
   logic            hold_last;

   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (u_pulse) n_pulse++;
         if (prev_hold && m_tvalid) begin
            chk("hold_tdata", 64'(m_tdata), 64'(hold_data));
            chk("hold_tid",   64'(m_tid),   64'(hold_tid));
            chk("hold_tlast", 64'(m_tlast), 64'(hold_last));
         end
         if (m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_output", 64'(m_tid), 64'hFFFF);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("out_tid",   64'(m_tid),   64'(e.tid));
               chk("out_tdata", 64'(m_tdata), 64'(e.data));
               chk("out_tlast", 64'(m_tlast), 64'(e.last));
            end
         end
         prev_hold = m_tvalid && !m_tready;
         hold_data = m_tdata;
         hold_tid  = m_tid;
         hold_last = m_tlast;
      end
   end

   initial begin
      rst        = 1'b1;
      enable     = 1'b0;
      ch_mask    = '0;
      frame_tick = 1'b0;
      s_tvalid   = '0;
      m_tready   = 1'b0;
      for (int i = 0; i < NUM_CH; i++) s_tdata[32*i +: 32] = 32'h1111_0000 + 32'(i);
      step();
      step();

      // reset state
      chk("rst_tvalid", 64'(m_tvalid), 0);
      chk("rst_tdata",  64'(m_tdata),  0);
      chk("rst_tid",    64'(m_tid),    0);
      chk("rst_tlast",  64'(m_tlast),  0);
      chk("rst_ready",  64'(s_tready), 0);
      chk("rst_pulse",  64'(u_pulse),  0);
      chk("rst_cnt",    64'(u_cnt),    0);
      chk("rst_busy",   64'(busy),     0);

      // basic frame, mask 0x05
      rst      = 1'b0;
      enable   = 1'b1;
      ch_mask  = 8'h05;
      s_tvalid = 8'hFF;
      m_tready = 1'b1;
      step();
      step();
      push(0, 0, 0);
      push(2, 0, 1);
      pulse_tick();
      chk("t1_ready_ch0", 64'(s_tready), 64'h01);
      step();
      chk("t1_ready_ch2", 64'(s_tready), 64'h04);
      chk("t1_tvalid",    64'(m_tvalid), 1);
      step();
      chk("t1_ready_off", 64'(s_tready), 0);
      step();
      chk("t1_busy_clear", 64'(busy), 0);
      chk("t1_sb_empty",   64'(sb.size()), 0);

      // backpressure: first output held for 5 cycles
      m_tready = 1'b0;
      push(0, 0, 0);
      push(2, 0, 1);
      pulse_tick();
      step();
      for (int i = 0; i < 5; i++) begin
         chk("t2_ready_blocked", 64'(s_tready), 0);
         chk("t2_held_tid",      64'(m_tid),    0);
         chk("t2_held_valid",    64'(m_tvalid), 1);
         step();
      end
      m_tready = 1'b1;
      #1;
      chk("t2_ready_ch2", 64'(s_tready), 64'h04);
      step();
      step();
      step();
      chk("t2_busy_clear", 64'(busy), 0);
      chk("t2_sb_empty",   64'(sb.size()), 0);

      // underrun: ch2 never valid, tick held into the FILL cycle too
      ch_mask  = 8'h0F;
      s_tvalid = 8'hFB;
      n_pulse  = 0;
      push(0, 0, 0);
      push(1, 0, 0);
      push(2, 1, 0);
      push(3, 1, 1);
      push(0, 0, 0);
      push(1, 0, 0);
      push(2, 0, 0);
      push(3, 0, 1);
      pulse_tick();
      step();
      step();
      step();
      frame_tick = 1'b1;
      step();
      step();
      frame_tick = 1'b0;
      chk("t3_cnt_one", 64'(u_cnt), 1);
      for (int i = 0; i < 4; i++) step();
      s_tvalid = 8'hFF;
      for (int i = 0; i < 5; i++) step();
      chk("t3_pulse_count", 64'(n_pulse), 1);
      chk("t3_cnt_final",   64'(u_cnt),   1);
      chk("t3_busy_clear",  64'(busy),    0);
      chk("t3_sb_empty",    64'(sb.size()), 0);

      // mask change mid-frame only affects the next frame
      ch_mask = 8'h03;
      push(0, 0, 0);
      push(1, 0, 1);
      pulse_tick();
      ch_mask = 8'h80;
      for (int i = 0; i < 4; i++) step();
      push(7, 0, 1);
      pulse_tick();
      chk("t4_ready_ch7", 64'(s_tready), 64'h80);
      for (int i = 0; i < 4; i++) step();
      chk("t4_busy_clear", 64'(busy), 0);
      chk("t4_sb_empty",   64'(sb.size()), 0);

      // counter saturation: 2**CNT_W+3 back-to-back underruns on ch0
      ch_mask  = 8'h01;
      s_tvalid = 8'h00;
      pulse_tick();
      step();
      for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
         push(0, 1, 1);
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         step();
      end
      chk("t5_cnt_sat", 64'(u_cnt), 64'((1 << CNT_W) - 1));
      push(0, 0, 1);
      s_tvalid = 8'h01;
      step();
      step();
      step();
      chk("t5_sb_empty", 64'(sb.size()), 0);
      ch_mask = 8'h00;
      pulse_tick();
      for (int i = 0; i < 4; i++) begin
         chk("t5_empty_mask_busy",   64'(busy),     0);
         chk("t5_empty_mask_tvalid", 64'(m_tvalid), 0);
         step();
      end
      chk("t5_cnt_still_sat", 64'(u_cnt), 64'((1 << CNT_W) - 1));

      // enable drop with held output, then asynchronous reset mid-frame
      ch_mask  = 8'h03;
      s_tvalid = 8'h01;
      m_tready = 1'b1;
      pulse_tick();
      step();
      chk("t6_ready_ch1", 64'(s_tready), 64'h02);
      m_tready = 1'b0;
      enable   = 1'b0;
      #1;
      chk("t6_ready_drop", 64'(s_tready), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t6_held_valid", 64'(m_tvalid), 1);
         chk("t6_held_data",  64'(m_tdata),  64'h1111_0000);
         chk("t6_held_busy",  64'(busy),     1);
      end
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_tvalid", 64'(m_tvalid), 0);
      chk("t6_async_tdata",  64'(m_tdata),  0);
      chk("t6_async_cnt",    64'(u_cnt),    0);
      chk("t6_async_busy",   64'(busy),     0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         chk("t6_idle_ready", 64'(s_tready), 0);
         chk("t6_idle_busy",  64'(busy),     0);
      end
      enable = 1'b1;
      step();
      pulse_tick();
      chk("t6_rearm_ready", 64'(s_tready), 64'h01);
      step();
      chk("t6_final_sb_empty", 64'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
